// File: rtl/beep_arbiter.sv
// Fixed-priority arbiter sharing one buzzer tone generator between three requesters;
// each granted job plays N ON/OFF beeps of the requester's tone.
module beep_arbiter #(
    parameter logic [24:0] ON_CYCLES  = 25'd12_499_999,
    parameter logic [24:0] OFF_CYCLES = 25'd12_499_999,
    parameter logic [17:0] TONE_1_MAX = 18'd190840,
    parameter logic [17:0] TONE_2_MAX = 18'd170068,
    parameter logic [17:0] TONE_3_MAX = 18'd151515,
    parameter logic [17:0] TONE_4_MAX = 18'd143266,
    parameter logic [17:0] TONE_5_MAX = 18'd127551,
    parameter logic [17:0] TONE_6_MAX = 18'd113636,
    parameter logic [17:0] TONE_7_MAX = 18'd101215
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [2:0]  req,
    input  logic [2:0]  tone_sel0,
    input  logic [2:0]  tone_sel1,
    input  logic [2:0]  tone_sel2,
    input  logic [3:0]  beep_num0,
    input  logic [3:0]  beep_num1,
    input  logic [3:0]  beep_num2,
    input  logic        abort,
    output logic [2:0]  grant,
    output logic [2:0]  done,
    output logic        busy,
    output logic        tone_en,
    output logic [17:0] tone_max
);

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t      state;
    logic [24:0] dur_cnt;
    logic [3:0]  beeps_left;
    logic [2:0]  owner;

    logic [2:0]  win_onehot;
    logic [2:0]  win_sel;
    logic [3:0]  win_num;
    logic [3:0]  win_beeps;
    logic [17:0] win_tone_max;

    // Priority encoder: bit 0 wins, then bit 1, then bit 2.
    always_comb begin
        win_onehot = 3'b100;
        win_sel    = tone_sel2;
        win_num    = beep_num2;
        if (req[0]) begin
            win_onehot = 3'b001;
            win_sel    = tone_sel0;
            win_num    = beep_num0;
        end else if (req[1]) begin
            win_onehot = 3'b010;
            win_sel    = tone_sel1;
            win_num    = beep_num1;
        end
        win_beeps = (win_num == 4'd0) ? 4'd1 : win_num;
        case (win_sel)
            3'd1:    win_tone_max = TONE_1_MAX;
            3'd2:    win_tone_max = TONE_2_MAX;
            3'd3:    win_tone_max = TONE_3_MAX;
            3'd4:    win_tone_max = TONE_4_MAX;
            3'd5:    win_tone_max = TONE_5_MAX;
            3'd6:    win_tone_max = TONE_6_MAX;
            3'd7:    win_tone_max = TONE_7_MAX;
            default: win_tone_max = 18'd0;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            dur_cnt    <= 25'd0;
            beeps_left <= 4'd0;
            owner      <= 3'b000;
            grant      <= 3'b000;
            done       <= 3'b000;
            busy       <= 1'b0;
            tone_en    <= 1'b0;
            tone_max   <= 18'd0;
        end else begin
            grant <= 3'b000;
            done  <= 3'b000;
            if (abort && state != IDLE) begin
                // Cancelled job: drop straight to idle without a done pulse.
                state      <= IDLE;
                dur_cnt    <= 25'd0;
                beeps_left <= 4'd0;
                owner      <= 3'b000;
                busy       <= 1'b0;
                tone_en    <= 1'b0;
                tone_max   <= 18'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!abort && req != 3'b000) begin
                            state      <= ON;
                            dur_cnt    <= 25'd0;
                            beeps_left <= win_beeps;
                            owner      <= win_onehot;
                            grant      <= win_onehot;
                            busy       <= 1'b1;
                            tone_max   <= win_tone_max;
                            tone_en    <= (win_sel != 3'd0);
                        end
                    end
                    ON: begin
                        if (dur_cnt == ON_CYCLES) begin
                            state      <= OFF;
                            dur_cnt    <= 25'd0;
                            beeps_left <= beeps_left - 4'd1;
                            tone_en    <= 1'b0;
                        end else begin
                            dur_cnt <= dur_cnt + 25'd1;
                        end
                    end
                    OFF: begin
                        if (dur_cnt == OFF_CYCLES) begin
                            dur_cnt <= 25'd0;
                            if (beeps_left != 4'd0) begin
                                state   <= ON;
                                // Every audible tone has a non-zero divider, so zero marks a silent job.
                                tone_en <= (tone_max != 18'd0);
                            end else begin
                                state    <= IDLE;
                                busy     <= 1'b0;
                                tone_max <= 18'd0;
                                done     <= owner;
                                owner    <= 3'b000;
                            end
                        end else begin
                            dur_cnt <= dur_cnt + 25'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_beep_arbiter.sv
// Self-checking bench for beep_arbiter: directed scenarios plus random traffic,
// compared each cycle against a job-timeline reference model.
module tb_beep_arbiter;

    localparam int ON_N   = 4;
    localparam int OFF_N  = 2;
    localparam int PERIOD = ON_N + OFF_N + 2;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [2:0]  req = 3'b000;
    logic [2:0]  tone_sel0 = 3'd0, tone_sel1 = 3'd0, tone_sel2 = 3'd0;
    logic [3:0]  beep_num0 = 4'd0, beep_num1 = 4'd0, beep_num2 = 4'd0;
    logic        abort = 1'b0;
    logic [2:0]  grant, done;
    logic        busy, tone_en;
    logic [17:0] tone_max;

    int checks = 0;
    int failures = 0;

    logic [17:0] tone_tab [8] = '{18'd0, 18'd190840, 18'd170068, 18'd151515,
                                  18'd143266, 18'd127551, 18'd113636, 18'd101215};

    // Reference model: a job is a start point plus elapsed cycles; outputs follow from arithmetic.
    bit          m_active = 0;
    int          m_k = 0, m_n = 0, m_id = 0;
    logic [17:0] m_tone = 18'd0;
    logic [2:0]  e_grant = 3'b000, e_done = 3'b000;
    logic        e_busy = 1'b0, e_tone_en = 1'b0;
    logic [17:0] e_tone_max = 18'd0;

    beep_arbiter #(
        .ON_CYCLES (25'd4),
        .OFF_CYCLES(25'd2)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .req      (req),
        .tone_sel0(tone_sel0),
        .tone_sel1(tone_sel1),
        .tone_sel2(tone_sel2),
        .beep_num0(beep_num0),
        .beep_num1(beep_num1),
        .beep_num2(beep_num2),
        .abort    (abort),
        .grant    (grant),
        .done     (done),
        .busy     (busy),
        .tone_en  (tone_en),
        .tone_max (tone_max)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [25:0] act_vec();
        return {grant, done, busy, tone_en, tone_max};
    endfunction

    function automatic logic [25:0] exp_vec();
        return {e_grant, e_done, e_busy, e_tone_en, e_tone_max};
    endfunction

    task automatic model_step();
        int sel;
        int num;
        e_grant = 3'b000;
        e_done  = 3'b000;
        if (!sys_rst_n) begin
            m_active = 0;
            e_busy = 0; e_tone_en = 0; e_tone_max = 18'd0;
        end else if (m_active) begin
            if (abort) begin
                m_active = 0;
                e_busy = 0; e_tone_en = 0; e_tone_max = 18'd0;
            end else begin
                m_k++;
                if (m_k == m_n * PERIOD) begin
                    m_active = 0;
                    e_busy = 0; e_tone_en = 0; e_tone_max = 18'd0;
                    e_done = 3'b001 << m_id;
                end else begin
                    e_busy     = 1;
                    e_tone_max = m_tone;
                    e_tone_en  = ((m_k % PERIOD) <= ON_N) && (m_tone != 18'd0);
                end
            end
        end else if (!abort && req != 3'b000) begin
            m_id = req[0] ? 0 : (req[1] ? 1 : 2);
            sel  = (m_id == 0) ? int'(tone_sel0) : (m_id == 1) ? int'(tone_sel1) : int'(tone_sel2);
            num  = (m_id == 0) ? int'(beep_num0) : (m_id == 1) ? int'(beep_num1) : int'(beep_num2);
            m_n  = (num == 0) ? 1 : num;
            m_tone = tone_tab[sel];
            m_active = 1;
            m_k = 0;
            e_grant    = 3'b001 << m_id;
            e_busy     = 1;
            e_tone_max = m_tone;
            e_tone_en  = (m_tone != 18'd0);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        model_step();
        #1;
        if (e_grant != 3'b000) $display("txn grant=%b tone_max=%0d beeps=%0d", e_grant, e_tone_max, m_n);
        if (e_done != 3'b000) $display("txn done=%b", e_done);
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if (act_vec() !== 26'd0) begin
            failures++;
            $display("FAIL reset_state: got=%h exp=%h", act_vec(), 26'd0);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL reset_idle: got=%h exp=%h", act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_basic();
        int busy_cnt = 0, ten_cnt = 0, bad_tone = 0;
        bit seen_done = 0;
        tone_sel0 = 3'd5;
        beep_num0 = 4'd2;
        req = 3'b001;
        for (int i = 0; i < 40 && !seen_done; i++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL basic_cycle%0d: got=%h exp=%h", i, act_vec(), exp_vec());
            end
            if (i == 0) begin
                checks++;
                if (grant !== 3'b001) begin
                    failures++;
                    $display("FAIL basic_grant: got=%b exp=001", grant);
                end
            end
            if (grant[0]) req[0] = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            if (tone_en === 1'b1) ten_cnt++;
            if (busy === 1'b1 && tone_max !== 18'd127551) bad_tone++;
            if (done !== 3'b000) begin
                seen_done = 1;
                checks++;
                if (done !== 3'b001 || busy !== 1'b0 || tone_max !== 18'd0) begin
                    failures++;
                    $display("FAIL basic_done: got done=%b busy=%b tone_max=%0d exp 001/0/0", done, busy, tone_max);
                end
            end
        end
        checks++;
        if (!seen_done || busy_cnt != 16 || ten_cnt != 10 || bad_tone != 0) begin
            failures++;
            $display("FAIL basic_timing: got busy=%0d tone_en=%0d bad_tone=%0d done=%0d exp 16/10/0/1",
                     busy_cnt, ten_cnt, bad_tone, seen_done);
        end
    endtask

    task automatic test_priority_back_to_back();
        int cyc_done1 = -10, cyc_grant2 = -1, busy1 = 0, busy2 = 0, ten2 = 0, tm2 = 0;
        int owner = 0;
        bit seen_done2 = 0;
        tone_sel1 = 3'd7; beep_num1 = 4'd0;
        tone_sel2 = 3'd0; beep_num2 = 4'd3;
        req = 3'b110;
        for (int i = 0; i < 60 && !seen_done2; i++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL prio_cycle%0d: got=%h exp=%h", i, act_vec(), exp_vec());
            end
            if (i == 0) begin
                checks++;
                if (grant !== 3'b010 || tone_max !== 18'd101215) begin
                    failures++;
                    $display("FAIL prio_grant: got grant=%b tone_max=%0d exp 010/101215", grant, tone_max);
                end
            end
            if (grant[1]) begin req[1] = 1'b0; owner = 1; end
            if (grant[2]) begin req[2] = 1'b0; owner = 2; cyc_grant2 = i; end
            if (busy === 1'b1 && owner == 1) busy1++;
            if (busy === 1'b1 && owner == 2) begin
                busy2++;
                if (tone_en === 1'b1) ten2++;
                if (tone_max !== 18'd0) tm2++;
            end
            if (done[1]) cyc_done1 = i;
            if (done[2]) seen_done2 = 1;
        end
        checks++;
        if (busy1 != 8 || cyc_grant2 != cyc_done1 + 1) begin
            failures++;
            $display("FAIL prio_b2b: got busy1=%0d grant2_gap=%0d exp 8/1", busy1, cyc_grant2 - cyc_done1);
        end
        checks++;
        if (!seen_done2 || busy2 != 24 || ten2 != 0 || tm2 != 0) begin
            failures++;
            $display("FAIL silent_job: got busy=%0d tone_en=%0d tone_max_nz=%0d done=%0d exp 24/0/0/1",
                     busy2, ten2, tm2, seen_done2);
        end
    endtask

    task automatic test_abort();
        int k = -1;
        bit aborted = 0, seen_done = 0;
        tone_sel0 = 3'($urandom_range(1, 7));
        beep_num0 = 4'd3;
        req = 3'b001;
        for (int i = 0; i < 40 && !aborted; i++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL abort_cycle%0d: got=%h exp=%h", i, act_vec(), exp_vec());
            end
            if (grant[0]) begin
                k = 0;
                req = 3'b100;
                tone_sel2 = 3'($urandom_range(0, 7));
                beep_num2 = 4'd1;
            end else if (k >= 0) begin
                k++;
            end
            if (k == PERIOD + 1) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                aborted = 1;
                checks++;
                if (act_vec() !== 26'd0 || exp_vec() !== 26'd0) begin
                    failures++;
                    $display("FAIL abort_idle: got=%h exp=%h", act_vec(), 26'd0);
                end
                tick();
                checks++;
                if (grant !== 3'b100 || act_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL abort_regrant: got=%h exp=%h", act_vec(), exp_vec());
                end
                req = 3'b000;
            end
        end
        checks++;
        if (!aborted) begin
            failures++;
            $display("FAIL abort_timeout: got aborted=0 exp 1");
        end
        for (int i = 0; i < 20 && !seen_done; i++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL abort_tail%0d: got=%h exp=%h", i, act_vec(), exp_vec());
            end
            if (done !== 3'b000) seen_done = 1;
        end
        abort = 1'b1;
        req = 3'b001;
        tick();
        abort = 1'b0;
        checks++;
        if (grant !== 3'b000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_abort_block: got grant=%b busy=%b exp 000/0", grant, busy);
        end
        tick();
        checks++;
        if (grant !== 3'b001 || act_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL idle_abort_release: got=%h exp=%h", act_vec(), exp_vec());
        end
        req = 3'b000;
        seen_done = 0;
        for (int i = 0; i < 40 && !seen_done; i++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL abort_job3_%0d: got=%h exp=%h", i, act_vec(), exp_vec());
            end
            if (done !== 3'b000) seen_done = 1;
        end
    endtask

    task automatic test_reset_midjob();
        int k = -1;
        bit hit = 0;
        tone_sel0 = 3'($urandom_range(1, 7));
        beep_num0 = 4'd2;
        req = 3'b001;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL rstmid_cycle%0d: got=%h exp=%h", i, act_vec(), exp_vec());
            end
            if (grant[0]) begin k = 0; req = 3'b000; end
            else if (k >= 0) k++;
            if (k == ON_N + 2) hit = 1;
        end
        #2 sys_rst_n = 1'b0;
        #1;
        checks++;
        if (!hit || act_vec() !== 26'd0) begin
            failures++;
            $display("FAIL rstmid_async: got=%h hit=%0d exp=%h", act_vec(), hit, 26'd0);
        end
        tick();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec() || busy !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_idle%0d: got=%h exp=%h", i, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            for (int r = 0; r < 3; r++) begin
                if (!req[r] && $urandom_range(0, 7) == 0) begin
                    req[r] = 1'b1;
                    if (r == 0) begin tone_sel0 = 3'($urandom_range(0, 7)); beep_num0 = 4'($urandom_range(0, 3)); end
                    if (r == 1) begin tone_sel1 = 3'($urandom_range(0, 7)); beep_num1 = 4'($urandom_range(0, 3)); end
                    if (r == 2) begin tone_sel2 = 3'($urandom_range(0, 7)); beep_num2 = 4'($urandom_range(0, 3)); end
                end
            end
            abort = ($urandom_range(0, 40) == 0);
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random_cycle%0d: got=%h exp=%h", i, act_vec(), exp_vec());
            end
            req = req & ~grant;
        end
        abort = 1'b0;
        req = 3'b000;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority_back_to_back();
        test_abort();
        test_reset_midjob();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
